// File: rtl/std_fp_sdiv_pkg.sv
// Shared types and sizing helpers for the signed fixed-point divider.
// Iteration count and counter width are derived from the operand geometry.
package std_fp_sdiv_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } sdiv_state_t;

  // One quotient bit per cycle over the scaled dividend |left|<<FRACT_WIDTH.
  function automatic int sdiv_iter(input int width, input int fract_width);
    return width + fract_width;
  endfunction

  function automatic int sdiv_cnt_w(input int iter);
    return (iter > 1) ? $clog2(iter) : 1;
  endfunction

endpackage

// File: rtl/std_fp_udiv_core.sv
// Unsigned restoring divider: WIDTH+FRACT_WIDTH cycles after start, fin pulses for one cycle.
// No backpressure: start is accepted whenever asserted and restarts any operation in flight.
// Quotient and remainder hold their final values until the next start.
module std_fp_udiv_core
  import std_fp_sdiv_pkg::*;
#(
  parameter int WIDTH       = 32,
  parameter int FRACT_WIDTH = 24
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               start,
  input  logic [WIDTH+FRACT_WIDTH-1:0]       dividend,
  input  logic [WIDTH-1:0]                   divisor,
  output logic [WIDTH+FRACT_WIDTH-1:0]       quotient,
  output logic [WIDTH-1:0]                   remainder,
  output logic                               fin
);

  localparam int ITER  = sdiv_iter(WIDTH, FRACT_WIDTH);
  localparam int CNT_W = sdiv_cnt_w(ITER);

  logic [ITER-1:0]  q_sr;
  logic [WIDTH-1:0] rem_r;
  logic [WIDTH-1:0] div_r;
  logic [CNT_W-1:0] cnt;
  logic             busy;

  logic [WIDTH:0]   trial;
  logic             ge;
  logic [WIDTH-1:0] diff;
  logic [WIDTH-1:0] rem_nxt;

  // The partial remainder stays below the divisor, so the trial value and
  // the difference both fit without an extra carry bit beyond WIDTH+1.
  always_comb begin
    trial   = {rem_r, q_sr[ITER-1]};
    ge      = (trial >= {1'b0, div_r});
    diff    = trial[WIDTH-1:0] - div_r;
    rem_nxt = ge ? diff : trial[WIDTH-1:0];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      q_sr  <= '0;
      rem_r <= '0;
      div_r <= '0;
      cnt   <= '0;
      busy  <= 1'b0;
      fin   <= 1'b0;
    end else begin
      fin <= 1'b0;
      if (start) begin
        q_sr  <= dividend;
        rem_r <= '0;
        div_r <= divisor;
        cnt   <= '0;
        busy  <= 1'b1;
      end else if (busy) begin
        q_sr  <= {q_sr[ITER-2:0], ge};
        rem_r <= rem_nxt;
        if (cnt == CNT_W'(ITER - 1)) begin
          busy <= 1'b0;
          fin  <= 1'b1;
        end else begin
          cnt <= cnt + CNT_W'(1);
        end
      end
    end
  end

  assign quotient  = q_sr;
  assign remainder = rem_r;

endmodule

// File: rtl/std_fp_sdiv_pipe.sv
// Signed fixed-point divider; done pulses ITER+1 cycles after go (ITER=WIDTH+FRACT_WIDTH).
// go is only sampled in IDLE; operands and go are ignored while busy.
// STD_FP_SDIV_SAT_EN selects saturation on overflow / divide-by-zero instead of wrap / zero.
module std_fp_sdiv_pipe
  import std_fp_sdiv_pkg::*;
#(
  parameter int WIDTH       = 32,
  parameter int INT_WIDTH   = 8,
  parameter int FRACT_WIDTH = 24
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             go,
  input  logic [WIDTH-1:0] left,
  input  logic [WIDTH-1:0] right,
  output logic [WIDTH-1:0] out_quotient,
  output logic [WIDTH-1:0] out_remainder,
  output logic             done
);

  localparam int DW = sdiv_iter(WIDTH, FRACT_WIDTH);

  if (WIDTH != INT_WIDTH + FRACT_WIDTH) begin : g_cfg_err
    $error("std_fp_sdiv_pipe: WIDTH must equal INT_WIDTH + FRACT_WIDTH");
  end

  sdiv_state_t state, state_nxt;

  logic [WIDTH-1:0] lft_r;
  logic [WIDTH-1:0] rgt_r;
  logic             core_start;
  logic             core_fin;
  logic [DW-1:0]    q_mag;
  logic [WIDTH-1:0] r_mag;
  logic [WIDTH-1:0] abs_l;
  logic [WIDTH-1:0] abs_r;
  logic             q_neg;
  logic             div0;
  logic [WIDTH-1:0] q_low;
  logic [WIDTH-1:0] q_res;
  logic [WIDTH-1:0] rem_res;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (go) state_nxt = RUN;
      RUN:     if (core_fin) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign core_start = (state == IDLE) && go;

  // Magnitudes are unsigned WIDTH bits so the most-negative operand is exact.
  assign abs_l = left[WIDTH-1]  ? -left  : left;
  assign abs_r = right[WIDTH-1] ? -right : right;

  std_fp_udiv_core #(
    .WIDTH       (WIDTH),
    .FRACT_WIDTH (FRACT_WIDTH)
  ) u_core (
    .clk       (clk),
    .reset     (reset),
    .start     (core_start),
    .dividend  ({abs_l, {FRACT_WIDTH{1'b0}}}),
    .divisor   (abs_r),
    .quotient  (q_mag),
    .remainder (r_mag),
    .fin       (core_fin)
  );

  assign q_neg   = lft_r[WIDTH-1] ^ rgt_r[WIDTH-1];
  assign div0    = (rgt_r == '0);
  assign q_low   = q_neg ? -q_mag[WIDTH-1:0] : q_mag[WIDTH-1:0];
  assign rem_res = div0 ? lft_r : (lft_r[WIDTH-1] ? -r_mag : r_mag);

`ifdef STD_FP_SDIV_SAT_EN
  localparam logic [WIDTH-1:0] MAX_POS = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [DW-1:0]    LIM_POS = {{FRACT_WIDTH{1'b0}}, MAX_POS};
  localparam logic [DW-1:0]    LIM_NEG = {{FRACT_WIDTH{1'b0}}, MIN_NEG};

  logic ovf;
  logic sat_pos;

  always_comb begin
    ovf     = q_neg ? (q_mag > LIM_NEG) : (q_mag > LIM_POS);
    // A zero divisor has no true sign, so the dividend's sign picks the rail.
    sat_pos = div0 ? !lft_r[WIDTH-1] : !q_neg;
    q_res   = (ovf || div0) ? (sat_pos ? MAX_POS : MIN_NEG) : q_low;
  end
`else
  logic unused_q_hi;

  assign unused_q_hi = ^q_mag[DW-1:WIDTH];
  assign q_res       = div0 ? '0 : q_low;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= IDLE;
      lft_r         <= '0;
      rgt_r         <= '0;
      out_quotient  <= '0;
      out_remainder <= '0;
    end else begin
      state <= state_nxt;
      if (core_start) begin
        lft_r <= left;
        rgt_r <= right;
      end
      if (state == RUN && core_fin) begin
        out_quotient  <= q_res;
        out_remainder <= rem_res;
      end
    end
  end

  assign done = (state == DONE);

endmodule

// File: tb/tb_std_fp_sdiv_pipe.sv
// Randomised and directed checks of std_fp_sdiv_pipe (16.16 format) against an arithmetic model.
module tb_std_fp_sdiv_pipe;

  localparam int W    = 32;
  localparam int IW   = 16;
  localparam int FW   = 16;
  localparam int ITER = W + FW;
`ifdef STD_FP_SDIV_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic         clk   = 1'b0;
  logic         reset = 1'b0;
  logic         go    = 1'b0;
  logic [W-1:0] left  = '0;
  logic [W-1:0] right = '0;
  logic [W-1:0] out_quotient;
  logic [W-1:0] out_remainder;
  logic         done;

  int cyc    = 0;
  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [W-1:0] q;
    logic [W-1:0] r;
    int           due;
  } exp_t;

  exp_t         exp_q[$];
  logic [W-1:0] held_q = '0;
  logic [W-1:0] held_r = '0;

  std_fp_sdiv_pipe #(
    .WIDTH       (W),
    .INT_WIDTH   (IW),
    .FRACT_WIDTH (FW)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .go            (go),
    .left          (left),
    .right         (right),
    .out_quotient  (out_quotient),
    .out_remainder (out_remainder),
    .done          (done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got %h, want %h (cycle %0d)", name, act, want, cyc);
    end
  endtask

  // Signed division of the scaled dividend; SV integer division truncates toward zero
  // and % takes the dividend's sign, which is exactly the required fix-up.
  function automatic void model(input logic [W-1:0] l, input logic [W-1:0] r,
                                output logic [W-1:0] q, output logic [W-1:0] rm);
    longint a, d, qt, rt;
    a = longint'($signed(l)) * (longint'(1) << FW);
    d = longint'($signed(r));
    if (d == 0) begin
      rm = l;
      q  = SAT ? ((a >= 0) ? 32'h7FFF_FFFF : 32'h8000_0000) : 32'h0;
    end else begin
      qt = a / d;
      rt = a % d;
      rm = 32'(rt);
      if (SAT && (qt > 64'sh7FFF_FFFF || qt < -64'sh8000_0000))
        q = (qt > 0) ? 32'h7FFF_FFFF : 32'h8000_0000;
      else
        q = 32'(qt);
    end
  endfunction

  // Every cycle: done must match the scheduled completion, outputs must hold the last result.
  always @(negedge clk) begin
    logic exp_done;
    exp_done = 1'b0;
    if (!reset) begin
      exp_q.delete();
      held_q = '0;
      held_r = '0;
    end else if (exp_q.size() != 0 && exp_q[0].due == cyc) begin
      held_q   = exp_q[0].q;
      held_r   = exp_q[0].r;
      exp_done = 1'b1;
      void'(exp_q.pop_front());
    end
    chk("done", {31'b0, done}, {31'b0, exp_done});
    chk("quotient", out_quotient, held_q);
    chk("remainder", out_remainder, held_r);
  end

  // Called just after a rising edge while the DUT is idle; returns once it is idle again.
  task automatic do_op(input logic [W-1:0] l, input logic [W-1:0] r);
    logic [W-1:0] mq, mr;
    exp_t         e;
    int           n;
    model(l, r, mq, mr);
    go    = 1'b1;
    left  = l;
    right = r;
    n     = cyc + 1;
    e.q   = mq;
    e.r   = mr;
    e.due = n + ITER + 1;
    exp_q.push_back(e);
    @(posedge clk); #1;
    go    = 1'b0;
    left  = $urandom;
    right = $urandom;
    while (cyc < n + ITER + 2) begin
      @(posedge clk); #1;
    end
  endtask

  logic [W-1:0] lit_l  [5] = '{32'h0006_0000, 32'hFFF8_8000, 32'h0001_0000, 32'h0005_0000, 32'h7FFF_0000};
  logic [W-1:0] lit_r  [5] = '{32'h0002_0000, 32'h0002_0000, 32'h0003_0000, 32'h0000_0000, 32'h0000_0001};
  logic [W-1:0] lit_q  [5] = '{32'h0003_0000, 32'hFFFC_4000, 32'h0000_5555,
                               SAT ? 32'h7FFF_FFFF : 32'h0, SAT ? 32'h7FFF_FFFF : 32'h0};
  logic [W-1:0] lit_rm [5] = '{32'h0, 32'h0, 32'h0001_0000, 32'h0005_0000, 32'h0};

  initial begin
    logic [W-1:0] l, r, mq, mr;
    exp_t         e;
    int           n1;

    repeat (3) @(posedge clk);
    #1;
    chk("reset_q", out_quotient, 32'h0);
    chk("reset_r", out_remainder, 32'h0);
    chk("reset_done", {31'b0, done}, 32'h0);
    reset = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 5; i++) begin
      model(lit_l[i], lit_r[i], mq, mr);
      chk($sformatf("model_q[%0d]", i), mq, lit_q[i]);
      chk($sformatf("model_r[%0d]", i), mr, lit_rm[i]);
      do_op(lit_l[i], lit_r[i]);
      chk($sformatf("lit_q[%0d]", i), out_quotient, lit_q[i]);
      chk($sformatf("lit_r[%0d]", i), out_remainder, lit_rm[i]);
    end

    for (int i = 0; i < 40; i++) begin
      l = $urandom;
      case ($urandom_range(0, 9))
        0:       r = '0;
        1:       r = 32'h8000_0000;
        2, 3:    r = 32'($urandom_range(1, 255));
        4:       r = {16'h0, 16'($urandom)};
        default: r = $urandom;
      endcase
      if ($urandom_range(0, 1) == 1) r = -r;
      if ($urandom_range(0, 7) == 0) l = 32'h8000_0000;
      do_op(l, r);
    end

    // Reset twenty cycles into RUN: the pending result is dropped and outputs clear.
    go    = 1'b1;
    left  = 32'h0006_0000;
    right = 32'h0002_0000;
    n1    = cyc + 1;
    model(left, right, mq, mr);
    e.q = mq; e.r = mr; e.due = n1 + ITER + 1;
    exp_q.push_back(e);
    @(posedge clk); #1;
    go = 1'b0;
    while (cyc < n1 + 20) begin
      @(posedge clk); #1;
    end
    reset = 1'b0;
    #1;
    chk("mid_reset_q", out_quotient, 32'h0);
    chk("mid_reset_r", out_remainder, 32'h0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk); #1;
    chk("post_reset_q", out_quotient, 32'h0);

    // go held high: second operation is sampled two edges after the first done,
    // so the pulses are ITER+3 edges apart (50 non-done cycles in between).
    go    = 1'b1;
    left  = 32'hFFF8_8000;
    right = 32'h0002_0000;
    n1    = cyc + 1;
    model(left, right, mq, mr);
    e.q = mq; e.r = mr; e.due = n1 + ITER + 1;
    exp_q.push_back(e);
    while (cyc < n1 + 5) begin
      @(posedge clk); #1;
    end
    left  = 32'h0001_0000;
    right = 32'h0003_0000;
    model(left, right, mq, mr);
    e.q = mq; e.r = mr; e.due = n1 + ITER + 3 + ITER + 1;
    exp_q.push_back(e);
    while (cyc < n1 + ITER + 3) begin
      @(posedge clk); #1;
    end
    go    = 1'b0;
    left  = $urandom;
    right = $urandom;
    while (cyc < n1 + ITER + 3 + ITER + 3) begin
      @(posedge clk); #1;
    end
    chk("b2b_q", out_quotient, 32'h0000_5555);
    chk("b2b_r", out_remainder, 32'h0001_0000);

    repeat (4) @(posedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
